branch_resolve: RTL and testbench

- EX-stage counterpart to the IF-stage 2-bit branch predictor.
- Queues each prediction issued at fetch, checks it in order against the outcome EX computes, and drives the predictor's training inputs.
- On a misprediction it emits a registered flush/redirect to the front end and discards all younger (wrong-path) predictions.

---
 rtl/branch_resolve.sv | 107 ++++++++++
 tb/tb_branch_resolve.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// EX-side branch checker: in-order queue of IF predictions, trains predictor, flushes on mispredict.
// Latency: results registered one cycle after a pop; optional counters via BRANCH_RESOLVE_PERF_EN.
// Backpressure: none; pushes while full without a pop are dropped and flagged in sticky overflow.
module branch_resolve #(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pred_valid,
   input  logic              pred_taken,
   input  logic [ADDR_W-1:0] pred_pc,
   input  logic [ADDR_W-1:0] pred_target,
   input  logic              resolve_valid,
   input  logic              actual_taken,
   input  logic [ADDR_W-1:0] actual_target,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   output logic              flush,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic              upd_branch,
   output logic              upd_taken
`ifdef BRANCH_RESOLVE_PERF_EN
   ,
   output logic [31:0]       resolved_cnt,
   output logic [31:0]       mispredict_cnt
`endif
);

   localparam int PW = $clog2(DEPTH);

   logic [PW:0]       rd_ptr, wr_ptr;
   logic              q_taken  [DEPTH];
   logic [ADDR_W-1:0] q_pc     [DEPTH];
   logic [ADDR_W-1:0] q_target [DEPTH];

   logic              head_taken;
   logic [ADDR_W-1:0] head_pc, head_target;
   logic              pop_fire, push_fire, mispredict;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty = (rd_ptr == wr_ptr);
   assign full  = (rd_ptr[PW] != wr_ptr[PW]) && (rd_ptr[PW-1:0] == wr_ptr[PW-1:0]);

   assign head_taken  = q_taken[rd_ptr[PW-1:0]];
   assign head_pc     = q_pc[rd_ptr[PW-1:0]];
   assign head_target = q_target[rd_ptr[PW-1:0]];

   assign pop_fire   = resolve_valid & ~empty;
   assign mispredict = (head_taken != actual_taken) |
                       (head_taken & actual_taken & (head_target != actual_target));
   assign push_fire  = pred_valid & (~full | pop_fire) & ~(pop_fire & mispredict);

   always_ff @(posedge clk) begin
      if (push_fire) begin
         q_taken[wr_ptr[PW-1:0]]  <= pred_taken;
         q_pc[wr_ptr[PW-1:0]]     <= pred_pc;
         q_target[wr_ptr[PW-1:0]] <= pred_target;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         overflow    <= 1'b0;
         flush       <= 1'b0;
         redirect_pc <= '0;
         upd_branch  <= 1'b0;
         upd_taken   <= 1'b0;
      end else begin
         upd_branch <= pop_fire;
         flush      <= pop_fire & mispredict;
         if (pop_fire) begin
            upd_taken   <= actual_taken;
            redirect_pc <= actual_taken ? actual_target : head_pc + ADDR_W'(4);
         end
         if (pred_valid & full & ~pop_fire)
            overflow <= 1'b1;
         // A mispredict makes every younger entry wrong-path, so the queue restarts empty.
         if (pop_fire & mispredict) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (pop_fire)
               rd_ptr <= rd_ptr + (PW+1)'(1);
            if (push_fire)
               wr_ptr <= wr_ptr + (PW+1)'(1);
         end
      end
   end

`ifdef BRANCH_RESOLVE_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         resolved_cnt   <= '0;
         mispredict_cnt <= '0;
      end else if (pop_fire) begin
         resolved_cnt <= resolved_cnt + 32'd1;
         if (mispredict)
            mispredict_cnt <= mispredict_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with a reference queue model and an expected-result scoreboard.
module tb_branch_resolve;

   logic        clk = 1'b0;
   logic        rst;
   logic        pred_valid, pred_taken;
   logic [31:0] pred_pc, pred_target;
   logic        resolve_valid, actual_taken;
   logic [31:0] actual_target;
   logic        full, empty, overflow, flush, upd_branch, upd_taken;
   logic [31:0] redirect_pc;
`ifdef BRANCH_RESOLVE_PERF_EN
   logic [31:0] resolved_cnt, mispredict_cnt;
   int          m_res = 0, m_mis = 0;
`endif

   always #5 clk = ~clk;

   branch_resolve #(.ADDR_W(32), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .pred_valid(pred_valid), .pred_taken(pred_taken),
      .pred_pc(pred_pc), .pred_target(pred_target),
      .resolve_valid(resolve_valid), .actual_taken(actual_taken),
      .actual_target(actual_target),
      .full(full), .empty(empty), .overflow(overflow), .flush(flush),
      .redirect_pc(redirect_pc), .upd_branch(upd_branch), .upd_taken(upd_taken)
`ifdef BRANCH_RESOLVE_PERF_EN
      , .resolved_cnt(resolved_cnt), .mispredict_cnt(mispredict_cnt)
`endif
   );

   typedef struct packed {logic t; logic [31:0] pc; logic [31:0] tg;} ent_t;
   typedef struct packed {logic fl; logic [31:0] rpc; logic ut;} exp_t;

   ent_t        mq[$];
   exp_t        sb[$];
   logic        m_ovf = 1'b0;
   logic [31:0] last_rpc = '0;
   logic        last_ut = 1'b0;
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_flags();
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == 4));
      chk("overflow", 32'(overflow), 32'(m_ovf));
   endtask

   // One clock: drive inputs, predict outcome in the model, check registered results after the edge.
   task automatic step(input logic pv, input logic pt, input logic [31:0] ppc, input logic [31:0] ptg,
                       input logic rv, input logic at, input logic [31:0] atg);
      logic pop, mis, fullm, push;
      ent_t h;
      pred_valid = pv; pred_taken = pt; pred_pc = ppc; pred_target = ptg;
      resolve_valid = rv; actual_taken = at; actual_target = atg;
      pop = rv && (mq.size() > 0);
      mis = 1'b0;
      if (pop) begin
         h   = mq[0];
         mis = (h.t != at) || (h.t && at && (h.tg != atg));
         sb.push_back('{fl: mis, rpc: (at ? atg : h.pc + 32'd4), ut: at});
      end
      fullm = (mq.size() == 4);
      push  = pv && (!fullm || pop) && !(pop && mis);
      if (pv && fullm && !pop) m_ovf = 1'b1;
      if (pop) begin
         if (mis) mq.delete();
         else void'(mq.pop_front());
`ifdef BRANCH_RESOLVE_PERF_EN
         m_res++;
         if (mis) m_mis++;
`endif
      end
      if (push) mq.push_back('{t: pt, pc: ppc, tg: ptg});
      @(posedge clk); #1;
      if (pop) begin
         exp_t e = sb.pop_front();
         chk("upd_branch", 32'(upd_branch), 32'd1);
         chk("flush", 32'(flush), 32'(e.fl));
         chk("redirect_pc", redirect_pc, e.rpc);
         chk("upd_taken", 32'(upd_taken), 32'(e.ut));
         last_rpc = e.rpc;
         last_ut  = e.ut;
      end else begin
         chk("idle_upd_branch", 32'(upd_branch), 32'd0);
         chk("idle_flush", 32'(flush), 32'd0);
         chk("hold_redirect_pc", redirect_pc, last_rpc);
         chk("hold_upd_taken", 32'(upd_taken), 32'(last_ut));
      end
      chk_flags();
   endtask

   task automatic do_reset(input logic rv);
      rst = 1'b1; resolve_valid = rv; pred_valid = 1'b0;
      actual_taken = 1'b1; actual_target = 32'h0000_0BAD;
      @(posedge clk); #1;
      rst = 1'b0;
      mq.delete(); m_ovf = 1'b0; last_rpc = '0; last_ut = 1'b0;
`ifdef BRANCH_RESOLVE_PERF_EN
      m_res = 0; m_mis = 0;
`endif
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_upd_branch", 32'(upd_branch), 32'd0);
      chk("rst_upd_taken", 32'(upd_taken), 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      chk_flags();
   endtask

   initial begin
      rst = 1'b1; pred_valid = 0; pred_taken = 0; pred_pc = 0; pred_target = 0;
      resolve_valid = 0; actual_taken = 0; actual_target = 0;
      @(posedge clk); #1;
      do_reset(1'b0);

      // Resolves on an empty queue are ignored.
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1, 32'h44);

      // Correct not-taken prediction.
      step(1, 0, 32'h100, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      chk("nt_ok_flush", 32'(flush), 32'd0);

      // Not-taken predicted, taken actual: both entries discarded.
      step(1, 0, 32'h200, 0, 0, 0, 0);
      step(1, 0, 32'h208, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 1, 32'h400);
      chk("dir_mis_redirect", redirect_pc, 32'h400);
      chk("dir_mis_empty", 32'(empty), 32'd1);

      // Taken both ways but wrong target.
      step(1, 1, 32'h280, 32'h300, 0, 0, 0);
      step(0, 0, 0, 0, 1, 1, 32'h340);
      chk("tgt_mis_redirect", redirect_pc, 32'h340);

      // Fall-through PC wraps at the top of the address space.
      step(1, 1, 32'hFFFF_FFFC, 32'h10, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      chk("wrap_redirect", redirect_pc, 32'h0);
      chk("wrap_flush", 32'(flush), 32'd1);

      // Fill, overflow, push with concurrent correct pop, then drain in order.
      for (int i = 1; i <= 4; i++) step(1, 0, 32'(i * 16), 0, 0, 0, 0);
      step(1, 0, 32'h50, 0, 0, 0, 0);
      chk("ovf_set", 32'(overflow), 32'd1);
      step(1, 0, 32'h60, 0, 1, 0, 0);
      chk("full_kept", 32'(full), 32'd1);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 0);
      chk("drain_last", redirect_pc, 32'h64);

      // Push alongside a mispredicting pop is wrong-path and dropped.
      step(1, 1, 32'h700, 32'h800, 0, 0, 0);
      step(1, 0, 32'h900, 0, 1, 0, 0);
      chk("wrongpath_empty", 32'(empty), 32'd1);

      // Reset in the middle of traffic.
      step(1, 0, 32'hA00, 0, 0, 0, 0);
      step(1, 0, 32'hA04, 0, 0, 0, 0);
      do_reset(1'b1);
      step(0, 0, 0, 0, 1, 0, 0);

      // Correct taken prediction with matching target keeps younger entries.
      step(1, 1, 32'hB00, 32'h500, 0, 0, 0);
      step(1, 0, 32'hB10, 0, 1, 1, 32'h500);
      chk("tk_ok_redirect", redirect_pc, 32'h500);
      step(0, 0, 0, 0, 1, 1, 32'hC00);

`ifdef BRANCH_RESOLVE_PERF_EN
      chk("resolved_cnt", resolved_cnt, 32'(m_res));
      chk("mispredict_cnt", mispredict_cnt, 32'(m_mis));
`endif
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
